// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single synchronous 64K x 8 memory port.
// Fixed priority to M0, starvation guard and optional burst lock for M1.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned MAX_LOCK     = 16
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req_0,
  input  logic        write_0,
  input  logic [15:0] addr_0,
  input  logic [7:0]  wdata_0,
  output logic        gnt_0,
  output logic        ack_0,
  output logic [7:0]  rdata_0,
  input  logic        req_1,
  input  logic        write_1,
  input  logic [15:0] addr_1,
  input  logic [7:0]  wdata_1,
  output logic        gnt_1,
  output logic        ack_1,
  output logic [7:0]  rdata_1,
  input  logic        lock_1,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned LW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_LIM   = LW'((MAX_LOCK == 0) ? 0 : MAX_LOCK - 1);
  localparam logic          LOCK_EN    = (MAX_LOCK != 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          gnt_0_q, gnt_1_q;
  logic          ack_0_q, ack_1_q;
  logic          rd_ack_0_q, rd_ack_1_q;
  logic          wr_q;
  logic [7:0]    rdata_0_q, rdata_1_q;
  logic          force_1, keep_1;

  // Arbitration and counter next-state
  always_comb begin
    force_1  = req_1 && (starve_q == STARVE_MAX);
    keep_1   = (state_q == OWN1) && req_1 && lock_1 && LOCK_EN && (lock_q < LOCK_LIM);
    state_d  = IDLE;
    starve_d = '0;
    lock_d   = '0;
    if (force_1 || keep_1) state_d = OWN1;
    else if (req_0)        state_d = OWN0;
    else if (req_1)        state_d = OWN1;
    if (req_1 && (state_d != OWN1)) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end
    if (keep_1) lock_d = lock_q + 1'b1;
  end

  // Read data shows mem_rdata during a read ack, then holds until the next read ack
  assign rdata_0 = rd_ack_0_q ? mem_rdata : rdata_0_q;
  assign rdata_1 = rd_ack_1_q ? mem_rdata : rdata_1_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      lock_q     <= '0;
      gnt_0_q    <= 1'b0;
      gnt_1_q    <= 1'b0;
      ack_0_q    <= 1'b0;
      ack_1_q    <= 1'b0;
      rd_ack_0_q <= 1'b0;
      rd_ack_1_q <= 1'b0;
      wr_q       <= 1'b0;
      rdata_0_q  <= 8'h00;
      rdata_1_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      lock_q     <= lock_d;
      gnt_0_q    <= (state_d == OWN0);
      gnt_1_q    <= (state_d == OWN1);
      // Direction is captured at the grant edge, while the request is still stable
      wr_q       <= ((state_d == OWN0) && write_0) || ((state_d == OWN1) && write_1);
      ack_0_q    <= gnt_0_q;
      ack_1_q    <= gnt_1_q;
      rd_ack_0_q <= gnt_0_q && !wr_q;
      rd_ack_1_q <= gnt_1_q && !wr_q;
      rdata_0_q  <= rdata_0;
      rdata_1_q  <= rdata_1;
    end
  end

  assign gnt_0 = gnt_0_q;
  assign gnt_1 = gnt_1_q;
  assign ack_0 = ack_0_q;
  assign ack_1 = ack_1_q;

  // Memory port mux follows the current owner
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_write = 1'b0;
    if (state_q == OWN0) begin
      mem_addr  = addr_0;
      mem_wdata = wdata_0;
      mem_write = write_0;
    end else if (state_q == OWN1) begin
      mem_addr  = addr_1;
      mem_wdata = wdata_1;
      mem_write = write_1;
    end
  end

endmodule
